// File: rtl/semaphore_arbiter_bank_if.sv
// Request/status bundle between the CPU cores and the semaphore bank.
// The master modport is the core side and the slave modport is the bank side.
interface semaphore_arbiter_bank_if #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int AddrWidth          = 8
);
  logic [NumberOfCores-1:0]           SEMAPHOREBANK_ReqValid_fromCPU;
  logic [NumberOfCores-1:0]           SEMAPHOREBANK_ReqLock_fromCPU;
  logic [NumberOfCores*AddrWidth-1:0] SEMAPHOREBANK_Addr_fromCPU;
  logic [NumberOfCores-1:0]           SEMAPHOREBANK_Grant_toCPU;
  logic [NumberOfCores-1:0]           SEMAPHOREBANK_Blocking_toCPU;
  logic [NumberOfCores-1:0]           SEMAPHOREBANK_Error_toCPU;
  logic [NumberOfSemaphores-1:0]      SEMAPHOREBANK_Locked_toCPU;

  modport master (
    output SEMAPHOREBANK_ReqValid_fromCPU, SEMAPHOREBANK_ReqLock_fromCPU,
           SEMAPHOREBANK_Addr_fromCPU,
    input  SEMAPHOREBANK_Grant_toCPU, SEMAPHOREBANK_Blocking_toCPU,
           SEMAPHOREBANK_Error_toCPU, SEMAPHOREBANK_Locked_toCPU
  );

  modport slave (
    input  SEMAPHOREBANK_ReqValid_fromCPU, SEMAPHOREBANK_ReqLock_fromCPU,
           SEMAPHOREBANK_Addr_fromCPU,
    output SEMAPHOREBANK_Grant_toCPU, SEMAPHOREBANK_Blocking_toCPU,
           SEMAPHOREBANK_Error_toCPU, SEMAPHOREBANK_Locked_toCPU
  );
endinterface

// File: rtl/semaphore_arbiter_bank.sv
// Bank of owned hardware semaphores with round-robin lock arbitration per semaphore.
// Optional SEMAPHOREBANK_TIMEOUT_EN: forced release of locks held TimeoutCycles cycles.
module semaphore_arbiter_bank #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int AddrWidth          = 8,
  parameter int CoreIdxWidth       = 1,
  parameter int TimeoutCycles      = 1024
) (
  input logic                     SEMAPHOREBANK_Clk,
  input logic                     SEMAPHOREBANK_Rst_n,
  semaphore_arbiter_bank_if.slave bus
);
  localparam int NS          = NumberOfSemaphores;
  localparam int NC          = NumberOfCores;
  localparam int SemIdxWidth = (NS > 1) ? $clog2(NS) : 1;
  localparam int CoreSelW    = $clog2(NC);

  logic [NC-1:0]           req_valid, req_lock;
  logic [NC*AddrWidth-1:0] req_addr;

  assign req_valid = bus.SEMAPHOREBANK_ReqValid_fromCPU;
  assign req_lock  = bus.SEMAPHOREBANK_ReqLock_fromCPU;
  assign req_addr  = bus.SEMAPHOREBANK_Addr_fromCPU;

  logic [NS-1:0]           locked_q, locked_d;
  logic [CoreIdxWidth-1:0] owner_q  [NS];
  logic [CoreIdxWidth-1:0] owner_d  [NS];
  logic [CoreIdxWidth-1:0] rr_ptr_q [NS];
  logic [CoreIdxWidth-1:0] rr_ptr_d [NS];
  logic [NC-1:0]           grant_q, grant_d;
  logic [NC-1:0]           blocking_q, blocking_d;
  logic [NC-1:0]           error_q, error_d;

`ifdef SEMAPHOREBANK_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] hold_cnt_q [NS];
  logic [CntW-1:0] hold_cnt_d [NS];
`endif

  // Per-semaphore set of cores asking to lock a semaphore that was free at cycle start.
  logic [NC-1:0]          lock_req [NS];
  logic [AddrWidth-1:0]   addr_c;
  logic [SemIdxWidth-1:0] sem;
  logic [CoreSelW-1:0]    idx, win;
  logic                   found;
  int                     idx_i;

  // NOTE: every variable gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps this purely combinational (no latches).
  always_comb begin
    locked_d   = locked_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = '0;
    blocking_d = '0;
    error_d    = '0;
    addr_c     = '0;
    sem        = '0;
    idx        = '0;
    win        = '0;
    found      = 1'b0;
    idx_i      = 0;
    for (int s = 0; s < NS; s++) lock_req[s] = '0;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    // Classify each core's request against the state at cycle start.
    for (int c = 0; c < NC; c++) begin
      if (req_valid[c]) begin
        addr_c = req_addr[c*AddrWidth +: AddrWidth];
        sem    = SemIdxWidth'(addr_c);
        if (32'(addr_c) >= 32'(NS)) begin
          error_d[c] = 1'b1;
        end else if (!req_lock[c]) begin
          if (locked_q[sem] && owner_q[sem] == CoreIdxWidth'(c)) locked_d[sem] = 1'b0;
          else error_d[c] = 1'b1;
        end else if (locked_q[sem]) begin
          if (owner_q[sem] == CoreIdxWidth'(c)) grant_d[c] = 1'b1;
          else blocking_d[c] = 1'b1;
        end else begin
          // Provisionally a loser; the arbitration below clears it for the winner.
          blocking_d[c]      = 1'b1;
          lock_req[sem][c]   = 1'b1;
        end
      end
    end

    // Round-robin pick among lockers of each free semaphore.
    for (int s = 0; s < NS; s++) begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NC; i++) begin
        idx_i = int'(rr_ptr_q[s]) + i;
        if (idx_i >= NC) idx_i = idx_i - NC;
        idx = CoreSelW'(idx_i);
        if (!found && lock_req[s][idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found) begin
        locked_d[s]     = 1'b1;
        owner_d[s]      = CoreIdxWidth'(win);
        rr_ptr_d[s]     = (int'(win) + 1 == NC) ? '0 : CoreIdxWidth'(int'(win) + 1);
        grant_d[win]    = 1'b1;
        blocking_d[win] = 1'b0;
      end
    end

`ifdef SEMAPHOREBANK_TIMEOUT_EN
    // A lock still held after this cycle's owner unlock either times out or ages.
    for (int s = 0; s < NS; s++) begin
      if (locked_q[s] && locked_d[s]) begin
        if (hold_cnt_q[s] == CntW'(TimeoutCycles - 1)) begin
          locked_d[s] = 1'b0;
          for (int c = 0; c < NC; c++) begin
            if (owner_q[s] == CoreIdxWidth'(c)) begin
              error_d[c]    = 1'b1;
              grant_d[c]    = 1'b0;
              blocking_d[c] = 1'b0;
            end
          end
        end else begin
          hold_cnt_d[s] = hold_cnt_q[s] + 1'b1;
        end
      end else if (!locked_q[s] && locked_d[s]) begin
        hold_cnt_d[s] = '0;
      end
    end
`endif
  end

  // NOTE: owner and round-robin arrays are small flop arrays, not RAM; they are
  // reset so that an asserted reset drops every lock and restarts fairness.
  always_ff @(posedge SEMAPHOREBANK_Clk or negedge SEMAPHOREBANK_Rst_n) begin
    if (!SEMAPHOREBANK_Rst_n) begin
      locked_q   <= '0;
      grant_q    <= '0;
      blocking_q <= '0;
      error_q    <= '0;
      for (int s = 0; s < NS; s++) begin
        owner_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
`ifdef SEMAPHOREBANK_TIMEOUT_EN
        hold_cnt_q[s] <= '0;
`endif
      end
    end else begin
      // NOTE: non-blocking updates so all state moves together on the edge.
      locked_q   <= locked_d;
      grant_q    <= grant_d;
      blocking_q <= blocking_d;
      error_q    <= error_d;
      for (int s = 0; s < NS; s++) begin
        owner_q[s]  <= owner_d[s];
        rr_ptr_q[s] <= rr_ptr_d[s];
`ifdef SEMAPHOREBANK_TIMEOUT_EN
        hold_cnt_q[s] <= hold_cnt_d[s];
`endif
      end
    end
  end

  assign bus.SEMAPHOREBANK_Grant_toCPU    = grant_q;
  assign bus.SEMAPHOREBANK_Blocking_toCPU = blocking_q;
  assign bus.SEMAPHOREBANK_Error_toCPU    = error_q;
  assign bus.SEMAPHOREBANK_Locked_toCPU   = locked_q;
endmodule
